// File: rtl/imm_encoder.sv
// imm_encoder: scatters a 32-bit immediate into the RV32I I/S/B/J/U field
// positions of a base instruction word, flags immediates the format cannot
// represent, and delivers the result through a two-stage valid/ready pipeline.
module imm_encoder #(
  parameter int CNT_W  = 8,
  parameter bit STRICT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      imm_in,
  input  logic [2:0]       ImmSrc,
  input  logic [31:0]      base_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr_out,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;

  logic [31:0] enc_word;
  logic        fmt_ok;
  logic        illegal_src;
  logic        enc_err;

  logic        v1;
  logic [31:0] word1;
  logic        err1;
  logic        s2_load;

  // Scatter the immediate into its format-specific bit positions and
  // decide whether the format can hold the value without loss.
  always_comb begin
    enc_word    = base_instr;
    fmt_ok      = 1'b1;
    illegal_src = 1'b0;
    case (ImmSrc)
      FMT_I: begin
        enc_word[31:20] = imm_in[11:0];
        fmt_ok          = (&imm_in[31:11]) | (~|imm_in[31:11]);
      end
      FMT_S: begin
        enc_word[31:25] = imm_in[11:5];
        enc_word[11:7]  = imm_in[4:0];
        fmt_ok          = (&imm_in[31:11]) | (~|imm_in[31:11]);
      end
      FMT_B: begin
        enc_word[31]    = imm_in[12];
        enc_word[30:25] = imm_in[10:5];
        enc_word[11:8]  = imm_in[4:1];
        enc_word[7]     = imm_in[11];
        fmt_ok          = ((&imm_in[31:12]) | (~|imm_in[31:12])) & ~imm_in[0];
      end
      FMT_J: begin
        enc_word[31]    = imm_in[20];
        enc_word[30:21] = imm_in[10:1];
        enc_word[20]    = imm_in[11];
        enc_word[19:12] = imm_in[19:12];
        fmt_ok          = ((&imm_in[31:20]) | (~|imm_in[31:20])) & ~imm_in[0];
      end
      FMT_U: begin
        enc_word[31:12] = imm_in[31:12];
        fmt_ok          = ~|imm_in[11:0];
      end
      default: begin
        illegal_src = 1'b1;
      end
    endcase
    enc_err = illegal_src | (STRICT & ~fmt_ok);
  end

  // The output register frees up when empty or being drained; stage 1 can
  // take a new word whenever its current word moves on or it is empty.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !v1 || s2_load;

  // Two pipeline stages plus the saturating count of errored deliveries.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      word1     <= '0;
      err1      <= 1'b0;
      out_valid <= 1'b0;
      instr_out <= '0;
      out_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (in_ready) begin
        v1 <= in_valid;
        if (in_valid) begin
          word1 <= enc_word;
          err1  <= enc_err;
        end
      end
      if (s2_load) begin
        out_valid <= v1;
        if (v1) begin
          instr_out <= word1;
          out_err   <= err1;
        end
      end
      if (out_valid && out_ready && out_err && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed test-plan words, a
// backpressure stall, a long randomized stream checked against a decoding
// reference model, a mid-stream reset and counter saturation.
module tb_imm_encoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] imm_in;
  logic [2:0]  imm_src;
  logic [31:0] base_instr;

  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [31:0] instr_out, instr_out2;
  logic        out_err,   out_err2;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;

  imm_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .imm_in(imm_in), .ImmSrc(imm_src), .base_instr(base_instr),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .out_err(out_err), .err_count(err_count)
  );

  imm_encoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .imm_in(imm_in), .ImmSrc(imm_src), .base_instr(base_instr),
    .out_valid(out_valid2), .out_ready(out_ready), .instr_out(instr_out2),
    .out_err(out_err2), .err_count(err_count2)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] trunc;
    logic [31:0] base;
    logic [2:0]  src;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   err_total = 0;
  bit   check_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference decoder: what the decode stage recovers from an instruction.
  function automatic logic [31:0] decode(input logic [31:0] w, input logic [2:0] s);
    logic signed [31:0] t;
    case (s)
      3'd0: t = $signed({w[31:20], 20'b0}) >>> 20;
      3'd1: t = $signed({w[31:25], w[11:7], 20'b0}) >>> 20;
      3'd2: t = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0}) >>> 19;
      3'd3: t = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0, 11'b0}) >>> 11;
      default: t = {w[31:12], 12'b0};
    endcase
    return t;
  endfunction

  function automatic logic [31:0] field_mask(input logic [2:0] s);
    case (s)
      3'd0:    return 32'hFFF0_0000;
      3'd1:    return 32'hFE00_0F80;
      3'd2:    return 32'hFE00_0F80;
      3'd3:    return 32'hFFFF_F000;
      3'd4:    return 32'hFFFF_F000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // The value a format can actually carry: the immediate reduced to the
  // format's width (sign-extended) with unrepresentable low bits cleared.
  function automatic logic [31:0] trunc_of(input logic [31:0] imm, input logic [2:0] s);
    logic signed [31:0] t;
    case (s)
      3'd0, 3'd1: begin t = $signed(imm << 20) >>> 20; return t; end
      3'd2:       begin t = $signed(imm << 19) >>> 19; return t & ~32'd1; end
      3'd3:       begin t = $signed(imm << 11) >>> 11; return t & ~32'd1; end
      3'd4:       return imm & 32'hFFFF_F000;
      default:    return imm;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic [31:0] imm, input logic [2:0] s,
                                    input logic [31:0] base);
    exp_t e;
    e.trunc = trunc_of(imm, s);
    e.base  = base;
    e.src   = s;
    e.err   = (s > 3'd4) || (e.trunc != imm);
    return e;
  endfunction

  // Model bookkeeping at the clock edge: enqueue accepted words, retire
  // delivered ones and count errored deliveries.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      err_total = 0;
    end else begin
      if (out_valid && out_ready && q.size() > 0) begin
        if (q[0].err) err_total++;
        void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(make_exp(imm_in, imm_src, base_instr));
    end
  end

  // Per-cycle comparison of the DUT against the model, mid-cycle.
  bit          stalled_prev = 0;
  logic [31:0] prev_instr;
  logic        prev_err;
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 0;
    end else if (check_en) begin
      chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      if (q.size() == 0) chk("no_stale_out", out_valid, 1'b0);
      if (q.size() == 2) chk("full_out_valid", out_valid, 1'b1);
      if (out_valid && q.size() > 0) begin
        if (q[0].src > 3'd4) begin
          chk("illegal_passthru", instr_out, q[0].base);
        end else begin
          chk("base_bits", instr_out & ~field_mask(q[0].src), q[0].base & ~field_mask(q[0].src));
          chk("decode", decode(instr_out, q[0].src), q[0].trunc);
        end
        chk("err", out_err, q[0].err);
      end
      if (stalled_prev) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_instr", instr_out, prev_instr);
        chk("stall_err", out_err, prev_err);
      end
      chk("err_count", err_count, (err_total > 255) ? 255 : err_total);
      chk("err_count_sat2", err_count2, (err_total > 3) ? 3 : err_total);
      stalled_prev = out_valid && !out_ready;
      prev_instr   = instr_out;
      prev_err     = out_err;
    end
  end

  // One directed word through an empty pipeline with out_ready held high.
  task automatic send(input string name, input logic [31:0] imm, input logic [2:0] s,
                      input logic [31:0] base, input logic [31:0] exp_instr,
                      input logic exp_err);
    imm_in = imm; imm_src = s; base_instr = base; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_accept"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat1"}, out_valid, 1'b0);
    @(negedge clk);
    chk({name, "_lat2"}, out_valid, 1'b1);
    chk({name, "_instr"}, instr_out, exp_instr);
    chk({name, "_err"}, out_err, exp_err);
    @(posedge clk); #1;
    $display("txn %s imm=%h src=%0d base=%h -> instr=%h err=%0b", name, imm, s, base,
             instr_out, out_err);
  endtask

  task automatic rand_word();
    imm_src    = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    imm_in     = $urandom;
    if ($urandom_range(0, 2) != 0) imm_in = $signed(imm_in) >>> $urandom_range(10, 31);
    if ($urandom_range(0, 1) != 0) imm_in[0] = 1'b0;
    if (imm_src == 3'd4 && $urandom_range(0, 1) != 0) imm_in[11:0] = 12'h000;
    base_instr = $urandom;
  endtask

  initial begin
    logic [7:0] ec0;
    bit         acc;
    int         words;
    int         cyc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    imm_in = '0; imm_src = '0; base_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_err_count", err_count, 8'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    check_en = 1;

    // Directed words from the test plan.
    send("I_neg1", 32'hFFFF_FFFF, 3'd0, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    send("B_800",  32'h0000_0800, 3'd2, 32'h0000_0063, 32'h0000_00E3, 1'b0);
    send("J_odd",  32'h0000_0003, 3'd3, 32'h0000_006F, 32'h0020_006F, 1'b1);
    ec0 = err_count;
    send("I_ovf",  32'h0000_0800, 3'd0, 32'h0000_0013, 32'h8000_0013, 1'b1);
    @(negedge clk);
    chk("err_count_inc", err_count, ec0 + 8'd1);
    @(posedge clk); #1;
    send("U_lui",  32'h1234_5000, 3'd4, 32'h0000_0037, 32'h1234_5037, 1'b0);
    send("illegal", 32'h0000_0000, 3'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);

    // Fill both stages against a stalled consumer.
    out_ready = 1'b0; in_valid = 1'b1; rand_word();
    repeat (4) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) rand_word();
    end
    @(negedge clk);
    chk("stall_in_ready_low", in_ready, 1'b0);
    chk("stall_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;

    // Randomized stream with random backpressure and input gaps.
    words = 0; cyc = 0;
    while (words < 10000 && cyc < 60000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        words++;
        if (words <= 8)
          $display("txn stream#%0d src=%0d imm=%h base=%h", words, imm_src, imm_in, base_instr);
        rand_word();
        in_valid = ($urandom_range(0, 3) != 0);
      end else if (!in_valid) begin
        in_valid = 1'b1;
      end
    end
    chk("stream_budget", (words == 10000), 1'b1);
    $display("txn stream done words=%0d cycles=%0d", words, cyc);

    // Drain.
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    chk("drain_empty", q.size(), 0);

    // Reset with two words in flight.
    out_ready = 1'b0; in_valid = 1'b1; rand_word();
    @(posedge clk); #1; rand_word();
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_err_count", err_count, 8'h0);
    chk("midrst_in_ready", in_ready, 1'b1);
    $display("txn reset mid-stream out_valid=%0b err_count=%0d", out_valid, err_count);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Five errored words: wide counter reaches 5, 2-bit counter sticks at 3.
    repeat (5) begin
      imm_src = 3'd5; imm_in = $urandom; base_instr = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sat_wide", err_count, 8'd5);
    chk("sat_cnt2", err_count2, 2'd3);
    $display("txn saturation err_count=%0d err_count2=%0d", err_count, err_count2);

    check_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
